// File: rtl/i2c_rd_collector_pkg.sv
// Shared types and sizing for the I2C read-result collector.
package i2c_rd_collector_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned FCNT_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned ENT_W       = DATA_W + IDX_W + 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // FIFO entry layout, MSB first: domain, idx, last, data
  typedef struct packed {
    logic              domain;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/i2c_rd_fifo.sv
// Small synchronous FIFO of tagged read bytes; head entry is read straight from storage.
module i2c_rd_fifo
  import i2c_rd_collector_pkg::*;
#(
  parameter int unsigned DEPTH_P = DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata_c,
  output logic   full_c,
  output logic   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH_P);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH_P];
  logic        do_push;
  logic        do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty_c;
  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign do_push = push && (!full_c || do_pop);
  assign rdata_c = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH_P); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_rd_collector.sv
// Tags sequencer read bytes with frame index/domain and buffers them for a valid/ready consumer.
// Optional mid-frame idle timeout enabled by defining I2C_RD_TIMEOUT_EN.
module i2c_rd_collector
  import i2c_rd_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_done,
  input  logic              in_domain,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_domain,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              timeout
);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             fire_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;
  entry_t           wdata_c;
  entry_t           head_c;

  assign pop_c   = out_valid && out_ready;
  assign wdata_c = '{domain: in_domain, idx: idx_q, last: in_done, data: in_data};

  i2c_rd_fifo #(.DEPTH_P(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .pop     (pop_c),
    .wdata   (wdata_c),
    .rdata_c (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  assign out_valid  = !empty_c;
  assign out_data   = head_c.data;
  assign out_idx    = head_c.idx;
  assign out_domain = head_c.domain;
  assign out_last   = head_c.last;

`ifdef I2C_RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] idle_q;

  assign fire_c = (state_q == ST_FRAME) && !in_valid && !in_done &&
                  (idle_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          idle_q <= '0;
    else if (state_q != ST_FRAME || in_valid || fire_c) idle_q <= '0;
    else                                                 idle_q <= idle_q + 1'b1;
  end
`else
  assign fire_c = 1'b0;
`endif

  // Frame tracking FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid && !in_done) state_d = ST_FRAME;
      ST_FRAME: if (in_done || fire_c)    state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q <= state_d;
      timeout <= fire_c;
      // idx advances even for dropped bytes so later positions stay correct
      if (in_done || fire_c) idx_q <= '0;
      else if (in_valid)     idx_q <= idx_q + 1'b1;
      if (in_done) frame_cnt <= frame_cnt + 1'b1;
      if (in_valid && full_c && !pop_c) overflow <= 1'b1;
      else if (clr_ovf)                 overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_rd_collector.sv
// Directed bench for i2c_rd_collector with an expected-entry queue and per-cycle model checks.
module tb_i2c_rd_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_done;
  logic       in_domain;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_domain;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] frame_cnt;
  logic       overflow;
  logic       clr_ovf;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [11:0] q[$];
  logic [1:0]  m_idx;
  logic [7:0]  m_fcnt;
  logic        m_ovf;
  logic        m_frame;
  int          m_idle;

  i2c_rd_collector dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_done(in_done), .in_domain(in_domain), .out_data(out_data),
    .out_idx(out_idx), .out_domain(out_domain), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .frame_cnt(frame_cnt),
    .overflow(overflow), .clr_ovf(clr_ovf), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = '0; m_fcnt = '0; m_ovf = 1'b0; m_frame = 1'b0; m_idle = 0;
  endtask

  // One clock: check head/handshake before the edge, update model, check state after it
  task automatic tick();
    logic        pop;
    logic        full;
    logic        drop;
    logic        exp_to;
    logic [11:0] exp;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    pop  = out_ready && (q.size() != 0);
    full = (q.size() == 4);
    drop = in_valid && full && !pop;
    exp_to = 1'b0;
    if (pop) begin
      exp = q.pop_front();
      chk("head", 32'({out_domain, out_idx, out_last, out_data}), 32'(exp));
    end
    if (in_valid) begin
      if (!drop) q.push_back({in_domain, m_idx, in_done, in_data});
      m_idx = in_done ? 2'd0 : m_idx + 2'd1;
    end else if (in_done) m_idx = 2'd0;
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (in_done) m_fcnt = m_fcnt + 8'd1;
`ifdef I2C_RD_TIMEOUT_EN
    if (m_frame && !in_valid && !in_done) begin
      if (m_idle == 15) begin
        exp_to = 1'b1; m_frame = 1'b0; m_idx = 2'd0; m_idle = 0;
      end else m_idle++;
    end else m_idle = 0;
    if (in_done) m_frame = 1'b0;
    else if (in_valid) m_frame = 1'b1;
`endif
    @(posedge clk); #1;
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("timeout", 32'(timeout), 32'(exp_to));
  endtask

  task automatic drive(input logic v, input logic d, input logic dom, input logic [7:0] data);
    in_valid = v; in_done = d; in_domain = dom; in_data = data;
    tick();
    in_valid = 1'b0; in_done = 1'b0; in_domain = 1'b0; in_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // 1: reset with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; in_done = 1'b0; in_domain = 1'b1; in_data = 8'h77;
    out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({out_valid, out_data, out_idx, out_domain, out_last,
                              frame_cnt, overflow, timeout}), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; in_domain = 1'b0; in_data = 8'h00;
    idle(2);

    // 2: two-byte frame with idle gap, consumer always ready
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h12);
    idle(5);
    drive(1'b1, 1'b1, 1'b1, 8'h90);
    idle(2);
    chk("frame_cnt_after_t2", 32'(frame_cnt), 32'd1);

    // 3: overflow on fifth byte, drain, clear
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 1'b0, 8'(i));
    chk("overflow_set", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    idle(5);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    chk("overflow_clr", 32'(overflow), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);

    // 4: full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'hB0 + 8'(i));
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    idle(5);

    // Single-byte frame and done-alone frame close
    drive(1'b1, 1'b1, 1'b1, 8'h5C);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);

    // 5: reset mid-frame with buffered entries
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'hC1);
    drive(1'b1, 1'b0, 1'b1, 8'hC2);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_fcnt", 32'(frame_cnt), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'hD7);
    idle(2);

    // 6: long idle mid-frame (forced close only when the timeout is built in)
    drive(1'b1, 1'b0, 1'b0, 8'h34);
    idle(20);
    drive(1'b1, 1'b1, 1'b1, 8'h56);
    idle(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
